// File: rtl/adder_16bit_reg.sv
// adder_16bit_reg: registered 16-bit adder (two-level 4x4 carry-lookahead) with carry, overflow, zero and negative flags.
// Latency: 1 cycle from an accepted operand set to the result; throughput one result per cycle.
// Backpressure: none; every in_valid cycle is accepted once the reset release has completed.
// Optional feature: define ADDER16_SAT_EN to saturate sum on signed overflow (default build wraps).

module adder_16bit_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic        out_valid,
    output logic [15:0] sum,
    output logic        cout,
    output logic        overflow,
    output logic        zero,
    output logic        negative
);

    // Per-bit generate/propagate, per-group G/P, carries into each bit and each group.
    logic [15:0] w_g;
    logic [15:0] w_p;
    logic [15:0] w_c;
    logic [3:0]  w_gg;
    logic [3:0]  w_gp;
    logic [4:0]  w_cg;
    logic [15:0] w_sum_raw;
    logic [15:0] w_sum;
    logic        w_ovf;
    logic        w_accept;

    // Result and release registers.
    logic        r_rel;
    logic        r_vld;
    logic [15:0] r_sum;
    logic        r_cout;
    logic        r_ovf;
    logic        r_zero;
    logic        r_neg;

    // First-level lookahead: bit generate/propagate and group generate/propagate.
    always_comb begin
        w_g  = a & b;
        w_p  = a ^ b;
        w_gg = '0;
        w_gp = '0;
        for (int k = 0; k < 4; k++) begin
            w_gg[k] = w_g[4*k+3]
                    | (w_p[4*k+3] & w_g[4*k+2])
                    | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                    | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
            w_gp[k] = w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_p[4*k];
        end
    end

    // Second-level lookahead: group carries c4/c8/c12/c16 straight from cin.
    always_comb begin
        w_cg[0] = cin;
        w_cg[1] = w_gg[0] | (w_gp[0] & cin);
        w_cg[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & cin);
        w_cg[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                | (w_gp[2] & w_gp[1] & w_gp[0] & cin);
        w_cg[4] = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & cin);
    end

    // In-group carries, expanded in lookahead form from each group's carry-in.
    always_comb begin
        w_c = '0;
        for (int k = 0; k < 4; k++) begin
            w_c[4*k]   = w_cg[k];
            w_c[4*k+1] = w_g[4*k] | (w_p[4*k] & w_cg[k]);
            w_c[4*k+2] = w_g[4*k+1] | (w_p[4*k+1] & w_g[4*k])
                       | (w_p[4*k+1] & w_p[4*k] & w_cg[k]);
            w_c[4*k+3] = w_g[4*k+2] | (w_p[4*k+2] & w_g[4*k+1])
                       | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                       | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_cg[k]);
        end
    end

    // Sum bits and signed overflow, judged on the unsaturated (wrapped) result.
    always_comb begin
        w_sum_raw = w_p ^ w_c;
        w_ovf     = (a[15] == b[15]) && (w_sum_raw[15] != a[15]);
    end

`ifdef ADDER16_SAT_EN
    // Clamp to the representable extreme matching the operands' common sign.
    always_comb begin
        w_sum = w_sum_raw;
        if (w_ovf) begin
            w_sum = a[15] ? 16'h8000 : 16'h7FFF;
        end
    end
`else
    // Plain modulo-2^16 result.
    always_comb begin
        w_sum = w_sum_raw;
    end
`endif

    // Operands are taken only once the release flop has armed.
    always_comb begin
        w_accept = in_valid & r_rel;
    end

    // Reset release: the first edge after rst_n rises only arms r_rel (shift stage one),
    // and the result registers act as the second stage, so the second edge is the first
    // one that can accept operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rel <= 1'b0;
        end else begin
            r_rel <= 1'b1;
        end
    end

    // Result registers: load on accept, otherwise hold; out_valid tracks acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld  <= 1'b0;
            r_sum  <= 16'h0000;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
            r_neg  <= 1'b0;
        end else begin
            r_vld <= w_accept;
            if (w_accept) begin
                r_sum  <= w_sum;
                r_cout <= w_cg[4];
                r_ovf  <= w_ovf;
                r_zero <= (w_sum == 16'h0000);
                r_neg  <= w_sum[15];
            end
        end
    end

    assign out_valid = r_vld;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign overflow  = r_ovf;
    assign zero      = r_zero;
    assign negative  = r_neg;

endmodule

// File: tb/tb_adder_16bit_reg.sv
// Testbench for adder_16bit_reg: table vectors, random stream, idle hold, reset release and mid-stream reset.
// Expected results come from hand constants or a behavioural model, queued at drive time, popped at output.
// Outputs are sampled on the falling clock edge.

module tb_adder_16bit_reg;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        neg;
    } res_t;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        res_t        exp;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic [15:0] sum;
    logic        cout;
    logic        overflow;
    logic        zero;
    logic        negative;

    int   n_checks = 0;
    int   n_errors = 0;
    res_t sbq[$];
    res_t last;
    vec_t tbl[10];

    adder_16bit_reg dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow),
        .zero      (zero),
        .negative  (negative)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic res_t model(input logic [15:0] ma, input logic [15:0] mb, input logic mc);
        res_t        r;
        logic [16:0] t;
        t      = {1'b0, ma} + {1'b0, mb} + {16'h0000, mc};
        r.sum  = t[15:0];
        r.cout = t[16];
        r.ovf  = (ma[15] == mb[15]) && (t[15] != ma[15]);
        r.zero = (t[15:0] == 16'h0000);
        r.neg  = t[15];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_outputs(input string tag, input res_t e);
        chk({tag, ".sum"},      sum,             e.sum);
        chk({tag, ".cout"},     {15'd0, cout},     {15'd0, e.cout});
        chk({tag, ".overflow"}, {15'd0, overflow}, {15'd0, e.ovf});
        chk({tag, ".zero"},     {15'd0, zero},     {15'd0, e.zero});
        chk({tag, ".negative"}, {15'd0, negative}, {15'd0, e.neg});
    endtask

    // Drive one cycle from a falling edge; acc says whether the DUT should take it.
    task automatic step(input logic v, input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic tc, input res_t e, input logic acc, input string tag);
        res_t got;
        in_valid = v;
        a        = ta;
        b        = tb_v;
        cin      = tc;
        @(posedge clk);
        if (v && acc) sbq.push_back(e);
        @(negedge clk);
        chk({tag, ".out_valid"}, {15'd0, out_valid}, {15'd0, (v && acc)});
        if (out_valid) begin
            if (sbq.size() == 0) begin
                chk({tag, ".sb_empty"}, 16'd1, 16'd0);
            end else begin
                got = sbq.pop_front();
                chk_outputs(tag, got);
                last = got;
            end
        end else begin
            chk_outputs({tag, ".hold"}, last);
        end
    endtask

    initial begin
        res_t        e;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;

        tbl[0] = '{16'h0001, 16'h0002, 1'b0, '{16'h0003, 1'b0, 1'b0, 1'b0, 1'b0}};
        tbl[1] = '{16'hFFFF, 16'hFFFF, 1'b0, '{16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b1}};
        tbl[2] = '{16'h7FFF, 16'h8000, 1'b0, '{16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1}};
        tbl[3] = '{16'h7FFF, 16'h0001, 1'b0, '{16'h8000, 1'b0, 1'b1, 1'b0, 1'b1}};
        tbl[4] = '{16'h0000, 16'h0000, 1'b0, '{16'h0000, 1'b0, 1'b0, 1'b1, 1'b0}};
        tbl[5] = '{16'hFFFF, 16'h0000, 1'b1, '{16'h0000, 1'b1, 1'b0, 1'b1, 1'b0}};
        tbl[6] = '{16'h1234, 16'h4321, 1'b1, '{16'h5556, 1'b0, 1'b0, 1'b0, 1'b0}};
        tbl[7] = '{16'h8000, 16'h8000, 1'b0, '{16'h0000, 1'b1, 1'b1, 1'b1, 1'b0}};
        tbl[8] = '{16'h7FFF, 16'h0000, 1'b1, '{16'h8000, 1'b0, 1'b1, 1'b0, 1'b1}};
        tbl[9] = '{16'h8000, 16'hFFFF, 1'b0, '{16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0}};

        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
        rst_n    = 1'b1;
        last     = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state: everything zero, including the zero flag.
        chk("rst.out_valid", {15'd0, out_valid}, 16'd0);
        chk_outputs("rst", '0);

        // Release between edges; the first edge is ignored even with in_valid high.
        rst_n = 1'b1;
        step(1'b1, 16'h0005, 16'h0005, 1'b0, model(16'h0005, 16'h0005, 1'b0), 1'b0, "rel_edge1");

        // Table vectors, streamed back to back.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].exp, 1'b1, $sformatf("vec%0d", i));
        end

        // Random stream, then three idle cycles that must hold the last result.
        for (int i = 0; i < 24; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom_range(0, 1));
            step(1'b1, ra, rb, rc, model(ra, rb, rc), 1'b1, $sformatf("rnd%0d", i));
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 16'hAAAA, 16'h5555, 1'b1, '0, 1'b1, $sformatf("idle%0d", i));
        end

        // Mid-stream reset: outputs clear immediately, without a clock edge.
        step(1'b1, 16'h00F0, 16'h000F, 1'b0, model(16'h00F0, 16'h000F, 1'b0), 1'b1, "pre_rst");
        in_valid = 1'b1;
        a        = 16'h1111;
        b        = 16'h2222;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst.out_valid", {15'd0, out_valid}, 16'd0);
        chk_outputs("midrst", '0);
        last = '0;
        @(negedge clk);
        chk("midrst.sb_drained", 16'(sbq.size()), 16'd0);
        rst_n = 1'b1;
        step(1'b1, 16'h1111, 16'h2222, 1'b0, model(16'h1111, 16'h2222, 1'b0), 1'b0, "rel2_edge1");
        e = '{16'h0301, 1'b0, 1'b0, 1'b0, 1'b0};
        step(1'b1, 16'h0300, 16'h0000, 1'b1, e, 1'b1, "rel2_edge2");
        step(1'b0, 16'h0000, 16'h0000, 1'b0, '0, 1'b1, "rel2_idle");

        chk("end.sb_empty", 16'(sbq.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Hard stop so the run can never hang.
    initial begin
        #50000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
